// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state encoding and width helpers for the FIFO read packer
package fifo_rd_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

    // Bits needed to hold the value n (never less than one bit).
    function automatic int width_for(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEF_BEATS        = 4;
    localparam int DEF_FLUSH_CYCLES = 16;
    localparam int CNT_W            = width_for(DEF_BEATS);
    localparam int TMR_W            = width_for(DEF_FLUSH_CYCLES);

endpackage

// File: rtl/fifo_rd_flush_timer.sv
// rtl/fifo_rd_flush_timer.sv - idle counter that pulses expire after LIMIT enabled cycles
module fifo_rd_flush_timer
    import fifo_rd_pkg::*;
#(
    parameter int LIMIT = DEF_FLUSH_CYCLES,
    parameter int TMR_W = fifo_rd_pkg::TMR_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMR_W-1:0] count;

    // Expire on the enabled cycle that brings the count up to LIMIT.
    assign expire = en && !clr && (count == TMR_W'(LIMIT - 1));

    // Count enabled idle cycles; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs BEATS FIFO entries into one wide word; RD_PACK_FLUSH_EN adds idle flush
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int BEATS        = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                       rclk,
    input  logic                       rrstn,
    input  logic                       rempty,
    input  logic [DATA_SIZE-1:0]       rdata,
    output logic                       rinc,
    output logic [DATA_SIZE*BEATS-1:0] out_data,
    output logic [BEATS-1:0]           out_keep,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int LANE_CNT_W = width_for(BEATS);
    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(BEATS - 1);

    rd_state_e                        state;
    rd_state_e                        state_nxt;
    logic [LANE_CNT_W-1:0]            cnt;
    logic [BEATS-1:0][DATA_SIZE-1:0]  lanes;
    logic [BEATS-1:0]                 keep_q;
    logic                             hs;
    logic                             pop;
    logic                             last_lane;
    logic                             flush_expire;

    assign out_valid = (state == HOLD);
    assign hs        = out_valid && out_ready;
    // Back-pressure stops popping; a handshake frees the word so the same cycle may pop.
    assign pop       = !rempty && ((state == FILL) || hs);
    assign rinc      = pop && rrstn;
    assign last_lane = (cnt == LAST_LANE);
    assign out_data  = lanes;
    assign out_keep  = keep_q;

`ifdef RD_PACK_FLUSH_EN
    localparam int TMR_W_L = width_for(FLUSH_CYCLES);

    logic             tmr_en;
    logic             tmr_clr;
    logic [BEATS-1:0] partial_keep;

    assign tmr_en  = (state == FILL) && (cnt != '0) && rempty;
    // Holding the timer clear during HOLD guarantees a fresh count on entry to FILL.
    assign tmr_clr = pop || (state != FILL);

    fifo_rd_flush_timer #(
        .LIMIT (FLUSH_CYCLES),
        .TMR_W (TMR_W_L)
    ) u_flush_timer (
        .clk    (rclk),
        .rst_n  (rrstn),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (flush_expire)
    );

    // Keep mask for a flushed partial word: one bit per filled lane.
    always_comb begin
        partial_keep = '0;
        for (int i = 0; i < BEATS; i++) begin
            partial_keep[i] = (LANE_CNT_W'(i) < cnt);
        end
    end
`else
    assign flush_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: word complete (or flushed) enters HOLD; handshake leaves it.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if ((pop && last_lane) || flush_expire) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    state_nxt = (pop && (BEATS == 1)) ? HOLD : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Lane fill, lane counter and keep mask.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            lanes  <= '0;
            cnt    <= '0;
            keep_q <= '0;
        end else if ((state == HOLD) && hs) begin
            lanes  <= '0;
            keep_q <= '0;
            cnt    <= '0;
            if (pop) begin
                lanes[0] <= rdata;
                if (BEATS == 1) begin
                    keep_q <= '1;
                end else begin
                    cnt <= LANE_CNT_W'(1);
                end
            end
        end else if ((state == FILL) && pop) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt == LANE_CNT_W'(i)) begin
                    lanes[i] <= rdata;
                end
            end
            if (last_lane) begin
                cnt    <= '0;
                keep_q <= '1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
`ifdef RD_PACK_FLUSH_EN
        else if (flush_expire) begin
            keep_q <= partial_keep;
            cnt    <= '0;
        end
`endif
    end

endmodule
